fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
- Fetch sequencer for the dual-issue instruction ROM (2 words per read, 1-cycle read latency).
- Generates the word address, tracks reads that are in flight, and buffers returned bundles in a DEPTH-entry FIFO.
- Presents bundles to decode with a valid/ready handshake.
- Handles branch/jump redirects, including flushing stale reads, plus halt and ROM-end wrap.

Parameters:
- RESET_PC, 32'h0000_0000, byte PC loaded at reset; bits [1:0] ignored.
- DEPTH, 4, bundle FIFO entries (power of 2, at least 2).
- ADDR_W, 10, ROM word-address width (1024 words).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rom_addr  out  ADDR_W  word index to ROM (PC>>2); ROM returns rom[addr] and rom[addr+1] one cycle later.
- rom_instr1  in  32  ROM word at issued addr.
- rom_instr2  in  32  ROM word at issued addr+1.
- redirect_valid  in  1  taken branch/JAL; load new PC.
- redirect_pc  in  32  redirect target byte address.
- halt  in  1  suspend new ROM reads while high.
- out_ready  in  1  decode accepts the bundle.
- out_valid  out  1  FIFO head bundle valid.
- out_valid2  out  1  slot-2 instruction of the head bundle valid.
- out_pc  out  32  byte PC of slot 1 of the head bundle.
- out_instr1  out  32  slot-1 instruction.
- out_instr2  out  32  slot-2 instruction; 32'h00000013 when out_valid2=0.
- fifo_count  out  $clog2(DEPTH)+1  occupied FIFO entries.

Behaviour:
- Reset (asynchronous):
  - state=IDLE, rom_addr=RESET_PC[ADDR_W+1:2], FIFO empty, in-flight flag clear.
  - Outputs: out_valid=0, out_valid2=0, out_pc=0, out_instr1/2=32'h00000013, fifo_count=0.
- States:
  - IDLE: exactly one cycle after reset release, no issue, so the ROM's power-up NOPs are never captured. Always goes to RUN.
  - RUN: normal operation.
  - No other states. A reset asserted at any time forces IDLE, flushes the FIFO and drops any in-flight read.
- Issue rule:
  - In RUN, a read issues in cycle c when halt=0, redirect_valid=0 and fifo_count + inflight < DEPTH, where inflight is 0 or 1.
  - On issue, at the edge ending c: inflight<=1, the issued addr is recorded, and rom_addr <= rom_addr + 2 (mod 2^ADDR_W).
  - Steady-state throughput is 1 bundle (2 instructions) per cycle.
- Return:
  - In cycle c+1, if inflight=1 and not dropped, {rom_instr1, rom_instr2, pc = issued_addr<<2, valid2} is written at the edge ending c+1.
  - out_valid rises in cycle c+2, so first-bundle latency is 2 cycles after issue.
- FIFO:
  - Outputs are driven directly from the head entry, no extra latency.
  - A pop occurs when out_valid && out_ready.
  - Simultaneous write and pop are allowed, including when the FIFO is full: the credit check guarantees no overflow.
  - Pop when empty is ignored.
- ROM-end wrap:
  - An issue at addr = 2^ADDR_W - 1 stores valid2=0 and forces instr2=NOP (slot 2 is out of range).
  - Next rom_addr = 1.
- Redirect (highest priority):
  - In the cycle redirect_valid=1: no issue occurs. At the edge, the FIFO is flushed, an in-flight read issued the previous cycle is dropped (its data is not written), and rom_addr <= redirect_pc[ADDR_W+1:2].
  - The next cycle issues the target, so the target bundle appears at out_valid 3 cycles after the redirect cycle.
  - Redirect overrides a simultaneous pop (pop is discarded) and a simultaneous return.
  - Odd word targets are legal.
- Halt:
  - Blocks issue only. An in-flight return is still written, and the FIFO keeps draining.
  - Deassertion resumes issue from the held rom_addr.
- Back-to-back redirects: each one restarts from its target; only the last one takes effect.

Test Plan:
- Reset release, out_ready=1, ROM[0..7]=A..H: rom_addr sequence 0,2,4,6. First out_valid is 3 cycles after release with pc=0, A/B. Next cycle pc=8, C/D. No NOP bundle ever appears.
- out_ready=0 from reset, DEPTH=4: fifo_count saturates at 4. rom_addr stops at 8 and never exceeds 4 bundles. Raising ready pops pc=0,8,16,24 in order, then issue resumes.
- Redirect to 0x54 the cycle after an issue at addr 10: the bundle for addr 10 is never output, the FIFO is flushed, and 3 cycles later out_pc=0x54 with instr1=ROM[21], instr2=ROM[22].
- Redirect to 0xFFC (word 1023): bundle has out_pc=0xFFC, out_valid2=0, out_instr2=0x00000013. The next bundle has pc=0x004.
- Halt held 5 cycles with ready=1: the in-flight bundle is still delivered, then out_valid=0 and rom_addr is frozen. On release, sequential fetch continues with no duplicated or skipped PC.
- rst asserted mid-stream with a full FIFO: out_valid=0 and fifo_count=0 immediately (asynchronous). After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Dual-issue fetch sequencer: issues 2-word ROM reads, tracks the single
// in-flight read and buffers returned bundles in a small FIFO for decode.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4,
  parameter int          ADDR_W   = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [31:0]             rom_instr1,
  input  logic [31:0]             rom_instr2,
  input  logic                    redirect_valid,
  input  logic [31:0]             redirect_pc,
  input  logic                    halt,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic                    out_valid2,
  output logic [31:0]             out_pc,
  output logic [31:0]             out_instr1,
  output logic [31:0]             out_instr2,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int            PW      = $clog2(DEPTH);
  localparam logic [PW:0]   DEPTH_C = (PW+1)'(DEPTH);
  localparam logic [31:0]   NOP     = 32'h0000_0013;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t            state;
  logic              inflight;
  logic [ADDR_W-1:0] issued_addr;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW:0]       count;

  logic [31:0] mem_pc [DEPTH];
  logic [31:0] mem_i1 [DEPTH];
  logic [31:0] mem_i2 [DEPTH];
  logic        mem_v2 [DEPTH];

  logic [PW:0] credit_used;
  logic        issue;
  logic        push;
  logic        pop;
  logic        last_word;
  logic        unused_pc_bits;

  // Handshake: a bundle transfers on any cycle where out_valid && out_ready
  // are both high at the rising edge; out_valid never depends on out_ready.

  // The in-flight read already owns a FIFO slot, so the credit check counts it.
  assign credit_used = count + {{PW{1'b0}}, inflight};
  assign issue       = (state == RUN) && !halt && !redirect_valid && (credit_used < DEPTH_C);
  assign push        = inflight && !redirect_valid;
  assign pop         = (count != '0) && out_ready && !redirect_valid;
  assign last_word   = &issued_addr;

  assign unused_pc_bits = ^{redirect_pc[31:ADDR_W+2], redirect_pc[1:0], RESET_PC[31:ADDR_W+2], RESET_PC[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rom_addr    <= RESET_PC[ADDR_W+1:2];
      inflight    <= 1'b0;
      issued_addr <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      state <= RUN;
      if (redirect_valid) begin
        rom_addr <= redirect_pc[ADDR_W+1:2];
        inflight <= 1'b0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
      end else begin
        inflight <= issue;
        if (issue) begin
          issued_addr <= rom_addr;
          rom_addr    <= rom_addr + ADDR_W'(2);
        end
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      end
    end
  end

  // Slot 2 of a read at the last ROM word falls outside the ROM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr] <= {{(30-ADDR_W){1'b0}}, issued_addr, 2'b00};
      mem_i1[wr_ptr] <= rom_instr1;
      mem_i2[wr_ptr] <= last_word ? NOP : rom_instr2;
      mem_v2[wr_ptr] <= !last_word;
    end
  end

  assign out_valid  = (count != '0);
  assign out_valid2 = out_valid && mem_v2[rd_ptr];
  assign out_pc     = out_valid  ? mem_pc[rd_ptr] : 32'h0;
  assign out_instr1 = out_valid  ? mem_i1[rd_ptr] : NOP;
  assign out_instr2 = out_valid2 ? mem_i2[rd_ptr] : NOP;
  assign fifo_count = count;

endmodule
